// File: rtl/mod_pkg.sv
// Shared types for the mod-14 counter observer: event codes, FSM states,
// registered control bundle and the reference step of the counter.
package mod_pkg;

   localparam logic [3:0] MOD14_MAX = 4'd13;

   typedef enum logic [2:0] {
      WRAP_UP   = 3'd0,
      WRAP_DOWN = 3'd1,
      LOAD      = 3'd2,
      MISMATCH  = 3'd3,
      ILLEGAL   = 3'd4,
      CNT_RESET = 3'd5
   } evt_code_t;

   typedef enum logic {
      INIT  = 1'b0,
      TRACK = 1'b1
   } state_t;

   typedef struct packed {
      logic load;
      logic mode;
      logic cnt_rst;
   } ctl_t;

   // Value the counter should show one edge after holding v with direction up.
   function automatic logic [3:0] mod14_next(input logic [3:0] v, input logic up);
      if (up) return (v == MOD14_MAX) ? 4'd0 : v + 4'd1;
      else    return (v == 4'd0) ? MOD14_MAX : v - 4'd1;
   endfunction

endpackage

// File: rtl/mod14_evt_fifo.sv
// Small synchronous event FIFO with valid/ready pop and synchronous flush.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module mod14_evt_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 7
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          pop, wr_en;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == (AW+1)'(DEPTH));
   assign valid = ~empty;
   assign pop   = ~empty & ready;
   assign wr_en = push & (~full | pop);
   assign rdata = empty ? '0 : mem_q[rd_q];

   always_ff @(posedge clock) begin
      if (wr_en && !flush) mem_q[wr_q] <= wdata;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (wr_en) wr_q <= wr_q + AW'(1);
         if (pop)   rd_q <= rd_q + AW'(1);
         case ({wr_en, pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/mod14_event_monitor.sv
// Observer of the mod-14 up/down counter: classifies every transition against
// the control applied one edge earlier, counts wraps and queues non-routine events.
//
// state | meaning
// INIT  | first edge after reset/clr: capture prev value and controls, no check
// TRACK | classify prev -> cnt_in using the controls registered last edge
module mod14_event_monitor
   import mod_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int WC_W       = 16
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [3:0]      cnt_in,
   input  logic            load,
   input  logic            mode,
   input  logic            cnt_rst,
   input  logic            clr,
   output logic            wrap_up,
   output logic            wrap_down,
   output logic [WC_W-1:0] wrap_count,
   output logic            err_sticky,
   output logic            ovf_sticky,
   output logic            evt_valid,
   input  logic            evt_ready,
   output logic [2:0]      evt_code,
   output logic [3:0]      evt_value
);

   state_t          state_q;
   ctl_t            ctl_q;
   logic [3:0]      prev_q;
   logic [WC_W-1:0] wrap_cnt_q;
   logic            wrap_up_q, wrap_down_q, err_q, ovf_q;

   logic            ev_valid;
   evt_code_t       ev_code;
   logic [3:0]      exp_val;
   logic            push, drop, fifo_full, fifo_empty;
   logic [6:0]      fifo_rdata;

   always_comb begin
      ev_valid = 1'b0;
      ev_code  = LOAD;
      exp_val  = mod14_next(prev_q, ctl_q.mode);
      if (state_q == TRACK) begin
         if (cnt_in > MOD14_MAX) begin
            ev_valid = 1'b1;
            ev_code  = ILLEGAL;
         end else if (ctl_q.cnt_rst) begin
            ev_valid = 1'b1;
            ev_code  = (cnt_in != 4'd0) ? MISMATCH : CNT_RESET;
         end else if (ctl_q.load) begin
            ev_valid = 1'b1;
            ev_code  = LOAD;
         end else if (prev_q <= MOD14_MAX) begin
            // an illegal previous value has no defined successor, so it is not checked
            if (cnt_in != exp_val) begin
               ev_valid = 1'b1;
               ev_code  = MISMATCH;
            end else if (ctl_q.mode && prev_q == MOD14_MAX) begin
               ev_valid = 1'b1;
               ev_code  = WRAP_UP;
            end else if (!ctl_q.mode && prev_q == 4'd0) begin
               ev_valid = 1'b1;
               ev_code  = WRAP_DOWN;
            end
         end
      end
   end

   assign push = ev_valid & ~clr;
   // a full FIFO only takes the push if the head leaves on the same edge
   assign drop = push & fifo_full & ~evt_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= INIT;
         ctl_q       <= '0;
         prev_q      <= '0;
         wrap_cnt_q  <= '0;
         wrap_up_q   <= 1'b0;
         wrap_down_q <= 1'b0;
         err_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         ctl_q       <= {load, mode, cnt_rst};
         wrap_up_q   <= 1'b0;
         wrap_down_q <= 1'b0;
         if (clr) begin
            state_q    <= INIT;
            wrap_cnt_q <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
         end else begin
            state_q     <= TRACK;
            prev_q      <= cnt_in;
            wrap_up_q   <= ev_valid && (ev_code == WRAP_UP);
            wrap_down_q <= ev_valid && (ev_code == WRAP_DOWN);
            if (ev_valid && (ev_code == WRAP_UP || ev_code == WRAP_DOWN) && wrap_cnt_q != '1)
               wrap_cnt_q <= wrap_cnt_q + WC_W'(1);
            if (ev_valid && (ev_code == MISMATCH || ev_code == ILLEGAL))
               err_q <= 1'b1;
            if (drop)
               ovf_q <= 1'b1;
         end
      end
   end

   mod14_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (7)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .flush (clr),
      .push  (push),
      .wdata ({ev_code, cnt_in}),
      .ready (evt_ready),
      .valid (evt_valid),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign wrap_up    = wrap_up_q;
   assign wrap_down  = wrap_down_q;
   assign wrap_count = wrap_cnt_q;
   assign err_sticky = err_q;
   assign ovf_sticky = ovf_q;
   assign evt_code   = fifo_empty ? 3'd0 : fifo_rdata[6:4];
   assign evt_value  = fifo_empty ? 4'd0 : fifo_rdata[3:0];

endmodule

// File: tb/tb_mod14_event_monitor.sv
// Scoreboard bench for the mod-14 event monitor: expected FIFO entries are queued
// as stimulus is driven and compared as the DUT hands them out.
module tb_mod14_event_monitor;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  cnt_in = '0;
   logic        load = 1'b0, mode = 1'b0, cnt_rst = 1'b0, clr = 1'b0;
   logic        evt_ready = 1'b1;
   logic        wrap_up, wrap_down, err_sticky, ovf_sticky, evt_valid;
   logic [15:0] wrap_count;
   logic [2:0]  evt_code;
   logic [3:0]  evt_value;

   int          nvec = 0;
   int          nmis = 0;
   logic [6:0]  sb[$];

   localparam int C_WUP = 0, C_WDN = 1, C_LD = 2, C_MM = 3, C_ILL = 4, C_RST = 5;

   mod14_event_monitor #(.FIFO_DEPTH(4), .WC_W(16)) dut (
      .clock      (clock),
      .reset      (reset),
      .cnt_in     (cnt_in),
      .load       (load),
      .mode       (mode),
      .cnt_rst    (cnt_rst),
      .clr        (clr),
      .wrap_up    (wrap_up),
      .wrap_down  (wrap_down),
      .wrap_count (wrap_count),
      .err_sticky (err_sticky),
      .ovf_sticky (ovf_sticky),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_code   (evt_code),
      .evt_value  (evt_value)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus at the falling edge; pop/compare the head if it
   // leaves on the coming rising edge; return at the next falling edge.
   task automatic tick(input int c, input bit l, input bit m, input bit r,
                       input bit ev = 1'b0, input int code = 0, input bit cl = 1'b0);
      cnt_in  = 4'(c);
      load    = l;
      mode    = m;
      cnt_rst = r;
      clr     = cl;
      if (ev) sb.push_back({3'(code), 4'(c)});
      if (evt_valid && evt_ready) begin
         if (sb.size() == 0) chk("sb_underrun", 32'(evt_valid), 32'd0);
         else                chk("evt_head", {25'd0, evt_code, evt_value}, 32'(sb.pop_front()));
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      #12;
      chk("rst_valid", 32'(evt_valid), 0);
      chk("rst_wcnt", 32'(wrap_count), 0);
      chk("rst_err", 32'(err_sticky), 0);
      chk("rst_ovf", 32'(ovf_sticky), 0);
      chk("rst_code", 32'(evt_code), 0);
      @(negedge clock);
      reset = 1'b1;

      // up wrap
      tick(12, 0, 1, 0);
      tick(13, 0, 1, 0);
      tick(0, 0, 1, 0, 1, C_WUP);
      chk("wup_pulse", 32'(wrap_up), 1);
      chk("wup_dn", 32'(wrap_down), 0);
      chk("wup_cnt", 32'(wrap_count), 1);
      tick(1, 0, 0, 0);
      chk("wup_drop", 32'(wrap_up), 0);

      // down wrap
      tick(0, 0, 0, 0);
      tick(13, 0, 0, 0, 1, C_WDN);
      chk("wdn_pulse", 32'(wrap_down), 1);
      chk("wdn_cnt", 32'(wrap_count), 2);
      chk("wdn_err", 32'(err_sticky), 0);

      // load, then mismatch
      tick(12, 1, 0, 0);
      tick(5, 1, 0, 0, 1, C_LD);
      tick(9, 0, 1, 0, 1, C_LD);
      chk("load_err", 32'(err_sticky), 0);
      tick(11, 0, 1, 0, 1, C_MM);
      chk("mm_err", 32'(err_sticky), 1);

      // clear, then illegal value followed by a value with no defined predecessor
      tick(11, 0, 1, 0, 0, 0, 1);
      chk("clr_err", 32'(err_sticky), 0);
      chk("clr_wcnt", 32'(wrap_count), 0);
      tick(11, 0, 1, 0);
      tick(14, 0, 1, 0, 1, C_ILL);
      chk("ill_err", 32'(err_sticky), 1);
      tick(3, 0, 1, 0);
      tick(4, 0, 1, 0);
      chk("ill_after", 32'(evt_valid), 0);

      // counter reset: clean, then to a non-zero value
      tick(5, 0, 1, 1);
      tick(0, 0, 1, 0, 1, C_RST);
      tick(1, 0, 1, 0);
      tick(2, 0, 1, 1);
      tick(7, 0, 1, 0, 1, C_MM);
      tick(8, 0, 1, 0);

      // overflow with a stalled consumer
      tick(0, 0, 1, 0, 0, 0, 1);
      chk("clr2_ovf", 32'(ovf_sticky), 0);
      evt_ready = 1'b0;
      tick(0, 1, 1, 0);
      tick(1, 1, 1, 0, 1, C_LD);
      tick(2, 1, 1, 0, 1, C_LD);
      tick(3, 1, 1, 0, 1, C_LD);
      tick(4, 1, 1, 0, 1, C_LD);
      chk("full_ovf", 32'(ovf_sticky), 0);
      tick(5, 1, 1, 0);
      chk("ovf_set", 32'(ovf_sticky), 1);
      chk("ovf_valid", 32'(evt_valid), 1);
      evt_ready = 1'b1;
      tick(6, 1, 1, 0, 1, C_LD);
      tick(7, 0, 1, 0, 1, C_LD);
      for (int i = 8; i <= 11; i++) tick(i, 0, 1, 0);
      chk("drain_valid", 32'(evt_valid), 0);
      chk("drain_sb", 32'(sb.size()), 0);
      tick(11, 0, 1, 0, 0, 0, 1);
      chk("clr3_ovf", 32'(ovf_sticky), 0);
      chk("clr3_err", 32'(err_sticky), 0);
      chk("clr3_valid", 32'(evt_valid), 0);

      // wrap counter saturation
      tick(7, 0, 1, 0);
      tick(8, 0, 1, 0);
      force dut.wrap_cnt_q = 16'hFFFF;
      #1;
      chk("sat_forced", 32'(wrap_count), 32'hFFFF);
      release dut.wrap_cnt_q;
      for (int i = 9; i <= 13; i++) tick(i, 0, 1, 0);
      evt_ready = 1'b0;
      tick(0, 0, 1, 0, 1, C_WUP);
      chk("sat_pulse", 32'(wrap_up), 1);
      chk("sat_hold", 32'(wrap_count), 32'hFFFF);
      chk("sat_valid", 32'(evt_valid), 1);

      // asynchronous reset between edges with an entry still queued
      #2 reset = 1'b0;
      #1;
      chk("arst_pulse", 32'(wrap_up), 0);
      chk("arst_valid", 32'(evt_valid), 0);
      chk("arst_wcnt", 32'(wrap_count), 0);
      chk("arst_value", 32'(evt_value), 0);
      sb.delete();
      @(negedge clock);
      reset = 1'b1;
      evt_ready = 1'b1;
      tick(5, 0, 1, 0);
      chk("arst_init", 32'(evt_valid), 0);
      chk("arst_err", 32'(err_sticky), 0);
      tick(6, 0, 1, 0);
      chk("arst_track", 32'(evt_valid), 0);
      chk("end_sb", 32'(sb.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/mod14_event_monitor.md
Name: mod14_event_monitor

Overview:
- Downstream observer of the mod-14 up/down counter. Samples the counter output and its controls (load, mode, counter reset) every clock and classifies each transition.
- Raises wrap pulses and a saturating wrap count.
- Flags illegal values (14/15) and transitions that do not match the applied control.
- Queues non-routine events in a small FIFO drained through a valid/ready interface, consumed by a scoreboard or status logic.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2)
- WC_W, 16, width of wrap counter

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cnt_in  in  4  counter output value
- load  in  1  counter load control, as driven to the counter
- mode  in  1  counter direction as driven to the counter (1 = up, 0 = down)
- cnt_rst  in  1  counter's own reset, as driven to the counter
- clr  in  1  synchronous clear of statistics/FIFO
- wrap_up  out  1  one-cycle pulse: 13->0 with mode=1
- wrap_down  out  1  one-cycle pulse: 0->13 with mode=0
- wrap_count  out  WC_W  saturating count of wrap_up + wrap_down
- err_sticky  out  1  set on ILLEGAL or MISMATCH; cleared by clr
- ovf_sticky  out  1  event dropped because FIFO full; cleared by clr
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head
- evt_code  out  3  head event code
- evt_value  out  4  cnt_in captured with the event

Behaviour:
- Reset (reset=0, async): all outputs 0, FIFO empty, FSM=INIT, ctl_d=0, prev=0.

Control registration:
- ctl_d = {load, mode, cnt_rst}, registered every edge.
- The transition seen at edge k (prev -> cnt_in) is attributed to ctl_d captured at edge k-1.

FSM:
- INIT: capture prev=cnt_in and ctl_d. No classification. Go to TRACK next edge.
- TRACK: classify, then prev<=cnt_in.
- clr=1 in any state: wrap_count=0, stickies=0, FIFO flushed, pulses=0, state -> INIT. clr has priority over all updates.

Classification in TRACK (one event max per edge, priority order):
1. ILLEGAL (4): cnt_in>13.
2. CNT_RESET (5): ctl_d.cnt_rst=1. MISMATCH (3) instead if cnt_in!=0.
3. LOAD (2): ctl_d.load=1. Value not checked.
4. Expected value:
   - up: prev==13 ? 0 : prev+1
   - down: prev==0 ? 13 : prev-1
   - cnt_in != expected -> MISMATCH (3)
5. Match with prev=13, up -> WRAP_UP (0). Match with prev=0, down -> WRAP_DOWN (1).
6. Normal increment/decrement: no event, no FIFO push.
- If prev>13, step 4 is skipped: only ILLEGAL is possible, otherwise no event.

Outputs:
- wrap_up/wrap_down: registered, high exactly the cycle after the classifying edge.
- wrap_count: +1 per wrap, saturates at 2^WC_W-1.
- err_sticky: set on codes 3/4.

FIFO:
- Every classified event is pushed: {code, cnt_in}.
- Push when full -> entry dropped, ovf_sticky=1.
- Pop when evt_valid & evt_ready.
- Simultaneous push+pop when full: both succeed, no drop.
- Simultaneous push+pop when empty: pushed entry is visible next cycle; pop does not apply.
- Latency: event at edge k -> evt_valid=1 after edge k if the FIFO was empty.
- evt_code/evt_value hold while evt_valid & !evt_ready.
- Outputs are 0 when empty.

Reset mid-operation: asynchronous clear regardless of FIFO contents; first edge after release is INIT (no false MISMATCH).

Decomposition:
- Shared package mod_pkg:
  - MOD14_MAX = 13
  - typedef enum logic [2:0] evt_code_t: WRAP_UP, WRAP_DOWN, LOAD, MISMATCH, ILLEGAL, CNT_RESET
  - typedef state_t {INIT, TRACK}
- Sub-module: mod14_evt_fifo (parameterised synchronous FIFO, valid/ready pop, full/empty, async active-low reset, sync flush). Classifier and stats stay in the top module.

Test Plan:
- Up wrap: mode=1, cnt_in 12,13,0,1 -> one wrap_up pulse after the 13->0 edge; wrap_count=1; FIFO head {WRAP_UP, 0}.
- Down wrap: mode=0, cnt_in 1,0,13 -> wrap_down pulse; head {WRAP_DOWN, 13}; no error.
- Load and mismatch:
  - load=1 with cnt_in 5 -> 9: head {LOAD, 9}.
  - Then mode=1 with cnt_in 9 -> 11: {MISMATCH, 11}, err_sticky=1.
- Illegal: cnt_in=14 in TRACK -> {ILLEGAL, 14}, err_sticky=1. Next cnt_in=3 -> no event.
- FIFO overflow: evt_ready=0, 5 events with FIFO_DEPTH=4 -> 4 queued, ovf_sticky=1. Full + push + pop in the same cycle -> no drop. clr -> all stats 0, evt_valid=0.
- Async reset mid-stream: reset low between edges -> outputs 0 immediately; first edge after release produces no event; wrap_count saturation forced at 0xFFFF stays 0xFFFF on a further wrap.
